// File: rtl/obuft_ds_turnaround_ctrl.sv
// Round-robin owner of one differential tri-state pad pair: bounded bursts, Hi-Z turnaround between owners.
// Define OBUFT_DS_CTRL_PARK_DRIVE_EN to park the pair driven low (O_T=1, O_I=0) while IDLE.
module obuft_ds_turnaround_ctrl #(
    parameter int NUM_REQ           = 2,
    parameter int TURNAROUND_CYCLES = 2,
    parameter int MAX_BURST         = 16
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [NUM_REQ-1:0] REQ,
    input  logic [NUM_REQ-1:0] DATA,
    input  logic [NUM_REQ-1:0] LAST,
    output logic [NUM_REQ-1:0] GNT,
    output logic               O_I,
    output logic               O_T,
    output logic               BUSY,
    output logic               BURST_ABORT
);
    localparam int IW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TC_M1 = (TURNAROUND_CYCLES > 0) ? TURNAROUND_CYCLES - 1 : 0;
`ifdef OBUFT_DS_CTRL_PARK_DRIVE_EN
    localparam logic PARK_T = 1'b1;
`else
    localparam logic PARK_T = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_DRIVE = 2'd1, S_TURN = 2'd2} state_t;

    state_t             r_state, w_state;
    logic [NUM_REQ-1:0] r_gnt, w_gnt;
    logic [IW-1:0]      r_owner, w_owner;
    logic [IW-1:0]      r_ptr, w_ptr;
    logic [IW-1:0]      w_arb_idx, w_cand, w_ptr_after;
    logic [8:0]         r_beat, w_beat;
    logic [3:0]         r_turn, w_turn;
    logic               r_o_i, w_o_i;
    logic               r_o_t, w_o_t;
    logic               r_abort, w_abort;
    logic               r_busy;
    logic               w_arb_hit, w_end;
    logic               w_own_req, w_own_data, w_own_last;

    assign w_own_req   = REQ[r_owner];
    assign w_own_data  = DATA[r_owner];
    assign w_own_last  = LAST[r_owner];
    assign w_ptr_after = (r_owner == IW'(NUM_REQ - 1)) ? '0 : r_owner + IW'(1);

    // First requesting index at or after the pointer, wrapping.
    always_comb begin
        w_arb_hit = 1'b0;
        w_arb_idx = '0;
        w_cand    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_cand = IW'((int'(r_ptr) + i) % NUM_REQ);
            if (!w_arb_hit && REQ[w_cand]) begin
                w_arb_hit = 1'b1;
                w_arb_idx = w_cand;
            end
        end
    end

    always_comb begin
        w_state = r_state;
        w_gnt   = r_gnt;
        w_owner = r_owner;
        w_ptr   = r_ptr;
        w_beat  = r_beat;
        w_turn  = r_turn;
        w_o_i   = 1'b0;
        w_o_t   = 1'b0;
        w_abort = 1'b0;
        w_end   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_o_t = PARK_T;
                if (w_arb_hit) begin
                    w_state = S_DRIVE;
                    w_gnt   = NUM_REQ'(1) << w_arb_idx;
                    w_owner = w_arb_idx;
                    w_beat  = 9'd1;
                end
            end
            S_DRIVE: begin
                // A dropped request wins over LAST and the beat limit and consumes nothing.
                if (!w_own_req) begin
                    w_abort = 1'b1;
                    w_end   = 1'b1;
                end else begin
                    w_o_i = w_own_data;
                    w_o_t = 1'b1;
                    if (w_own_last || (r_beat == 9'(MAX_BURST))) w_end = 1'b1;
                    else w_beat = r_beat + 9'd1;
                end
                if (w_end) begin
                    w_gnt  = '0;
                    w_ptr  = w_ptr_after;
                    w_beat = '0;
                    w_turn = 4'(TC_M1);
                    w_state = (TURNAROUND_CYCLES == 0) ? S_IDLE : S_TURN;
                end
            end
            S_TURN: begin
                if (r_turn == 4'd0) w_state = S_IDLE;
                else w_turn = r_turn - 4'd1;
            end
            default: w_state = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
            r_gnt   <= '0;
            r_owner <= '0;
            r_ptr   <= '0;
            r_beat  <= '0;
            r_turn  <= '0;
            r_o_i   <= 1'b0;
            r_o_t   <= 1'b0;
            r_abort <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_gnt   <= w_gnt;
            r_owner <= w_owner;
            r_ptr   <= w_ptr;
            r_beat  <= w_beat;
            r_turn  <= w_turn;
            r_o_i   <= w_o_i;
            r_o_t   <= w_o_t;
            r_abort <= w_abort;
            r_busy  <= (w_state != S_IDLE);
        end
    end

    assign GNT         = r_gnt;
    assign O_I         = r_o_i;
    assign O_T         = r_o_t;
    assign BUSY        = r_busy;
    assign BURST_ABORT = r_abort;
endmodule
